inst_fetch_queue: RTL and testbench

- Fetch stage between the PC/instruction ROM and the Control/decode logic of the 16-bit, 10-bit-instruction processor.
- Issues sequential ROM reads ahead of decode and buffers the returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to decode with a valid/ready handshake.
- Flushes and restarts on a branch/jump redirect (the Target path) or on start, and stops issuing on halt.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/inst_fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, fetch FSM encoding and FIFO entry layout for the instruction fetch queue.
package fetch_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 10;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with single-cycle flush; the head is read from
// registered storage, so a pushed word is visible the cycle after the push.
module fetch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues in-order ROM reads ahead of decode, buffers {inst, pc} entries,
// flushes on redirect/start. Optional counters enabled by `define FETCH_STATS_EN.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_valid,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc,
    output logic [1:0]        state_o
`ifdef FETCH_STATS_EN
   ,output logic [15:0]       fetched_cnt,
    output logic [15:0]       flushed_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_L   = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_L = CW'(MAX_OUT);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            flush, resp, keep, issue, pop;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   inst_count, tag_count;
    logic            inst_empty, inst_full, tag_empty, tag_full;
    logic [PC_W-1:0] tag_pc;
    fetch_entry_t    push_entry, head_entry;
    logic            unused_fifo_status;

    assign flush       = start || redirect_valid;
    assign resp        = rom_valid && (outstanding_q != '0);
    // Responses of requests made before a flush are stale and only retire credits.
    assign keep        = resp && (drop_q == '0) && !flush && !tag_empty;
    assign credit_used = {1'b0, inst_count} + {1'b0, outstanding_q};
    assign issue       = (state_q == ST_RUN) && !flush && !tag_full
                         && (credit_used < DEPTH_L) && (outstanding_q < MAX_OUT_L);
    assign pop         = inst_valid && inst_ready;

    assign rom_req    = issue;
    assign rom_addr   = fetch_pc_q;
    assign inst_valid = !inst_empty;
    assign inst_out   = inst_empty ? '0 : head_entry.inst;
    assign inst_pc    = inst_empty ? '0 : head_entry.pc;
    assign state_o    = state_q;

    assign push_entry.inst = rom_data;
    assign push_entry.pc   = tag_pc;

    assign unused_fifo_status = &{1'b0, inst_full, tag_count};

    fetch_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_tag_q (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push_i  (issue),
        .data_i  (fetch_pc_q),
        .pop_i   (keep),
        .flush_i (flush),
        .head_o  (tag_pc),
        .count_o (tag_count),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    fetch_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_inst_q (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push_i  (keep),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head_entry),
        .count_o (inst_count),
        .empty_o (inst_empty),
        .full_o  (inst_full)
    );

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (halt) state_d = ST_HALTED;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
        drop_d        = drop_q;
        if (start)               fetch_pc_d = RESET_PC;
        else if (redirect_valid) fetch_pc_d = redirect_pc;
        else if (issue)          fetch_pc_d = pc_next(fetch_pc_q);
        // Everything still in flight after this cycle belongs to the old path.
        if (flush)                         drop_d = outstanding_q - CW'(resp);
        else if (resp && drop_q != '0)     drop_d = drop_q - 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetched_q, fetched_d;
    logic [15:0] flushed_q, flushed_d;
    logic [CW:0] discard;
    logic [16:0] flush_sum;

    // Popped entry is accepted by decode, so it is not counted as discarded.
    assign discard   = ({1'b0, inst_count} - (CW+1)'(pop))
                     + ({1'b0, outstanding_q} - {1'b0, drop_q});
    assign flush_sum = {1'b0, flushed_q} + 17'(discard);

    always_comb begin
        fetched_d = fetched_q;
        flushed_d = flushed_q;
        if (start) begin
            fetched_d = '0;
            flushed_d = '0;
        end else begin
            if (pop && fetched_q != 16'hFFFF) fetched_d = fetched_q + 1'b1;
            if (redirect_valid) flushed_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign fetched_cnt = fetched_q;
    assign flushed_cnt = flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order ROM responder of selectable latency.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        start, halt, redirect_valid;
  logic [15:0] redirect_pc;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_valid;
  logic [9:0]  rom_data;
  logic        inst_valid, inst_ready;
  logic [9:0]  inst_out;
  logic [15:0] inst_pc;
  logic [1:0]  state_o;
`ifdef FETCH_STATS_EN
  logic [15:0] fetched_cnt, flushed_cnt;
`endif

  inst_fetch_queue dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_req        (rom_req),
    .rom_addr       (rom_addr),
    .rom_valid      (rom_valid),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .state_o        (state_o)
`ifdef FETCH_STATS_EN
   ,.fetched_cnt    (fetched_cnt),
    .flushed_cnt    (flushed_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;
  int delivered, issued, popped;
  logic        sched_v [16];
  logic [15:0] sched_a [16];
  logic [15:0] iss_q[$];
  logic [15:0] pop_pc_q[$];
  logic [9:0]  pop_inst_q[$];
  logic        s_req, s_iv;
  logic [15:0] s_addr, s_pc;
  logic [9:0]  s_inst;

  function automatic logic [9:0] romword(input logic [15:0] a);
    logic [15:0] t;
    t = a ^ 16'h02A5;
    return t[9:0];
  endfunction

  // One clock cycle: drive ROM response, sample mid-cycle, record issues/pops, advance.
  task automatic tick();
    int slot;
    slot = cyc % 16;
    rom_valid = sched_v[slot];
    rom_data  = sched_v[slot] ? romword(sched_a[slot]) : 10'h0;
    if (sched_v[slot]) delivered++;
    sched_v[slot] = 1'b0;
    #3;
    s_req  = rom_req;
    s_addr = rom_addr;
    s_iv   = inst_valid;
    s_pc   = inst_pc;
    s_inst = inst_out;
    if (s_req) begin
      iss_q.push_back(s_addr);
      issued++;
      sched_v[(cyc + lat) % 16] = 1'b1;
      sched_a[(cyc + lat) % 16] = s_addr;
    end
    if (s_iv && inst_ready) begin
      pop_pc_q.push_back(s_pc);
      pop_inst_q.push_back(s_inst);
      popped++;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic clear_bench();
    iss_q.delete();
    pop_pc_q.delete();
    pop_inst_q.delete();
    delivered = 0;
    issued    = 0;
    popped    = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    inst_ready = 1'b0; rom_valid = 1'b0; rom_data = 10'h0;
    for (int i = 0; i < 16; i++) begin
      sched_v[i] = 1'b0;
      sched_a[i] = 16'h0;
    end
    tick();
    tick();
    RST_N = 1'b1;
    clear_bench();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    inst_ready = 1'b0; rom_valid = 1'b0; rom_data = 10'h0;
    for (int i = 0; i < 16; i++) begin
      sched_v[i] = 1'b0;
      sched_a[i] = 16'h0;
    end
    #2;
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req: got %b exp 0", rom_req); end
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_rom_addr: got %h exp 0000", rom_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b exp 0", inst_valid); end
    checks++; if (inst_out !== 10'h000) begin errors++; $display("FAIL reset_inst_out: got %h exp 000", inst_out); end
    checks++; if (inst_pc !== 16'h0000) begin errors++; $display("FAIL reset_inst_pc: got %h exp 0000", inst_pc); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", state_o, ST_IDLE); end
    @(posedge CLK);
    #1;
    tick();
    RST_N = 1'b1;
    clear_bench();
    tick();
    tick();
    checks++; if (iss_q.size() != 0) begin errors++; $display("FAIL idle_no_issue: got %0d requests exp 0", iss_q.size()); end
  endtask

  task automatic test_stream();
    int first_v;
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_v = -1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (s_iv && first_v < 0) first_v = i;
    end
    checks++; if (first_v != 3) begin errors++; $display("FAIL stream_first_valid: got cycle %0d exp 3", first_v); end
    checks++; if (state_o !== ST_RUN) begin errors++; $display("FAIL stream_state: got %0d exp %0d", state_o, ST_RUN); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= iss_q.size()) begin errors++; $display("FAIL stream_addr[%0d]: got none exp %h", k, k[15:0]); end
      else if (iss_q[k] !== k[15:0]) begin errors++; $display("FAIL stream_addr[%0d]: got %h exp %h", k, iss_q[k], k[15:0]); end
      checks++;
      if (k >= pop_pc_q.size()) begin errors++; $display("FAIL stream_pc[%0d]: got none exp %h", k, k[15:0]); end
      else if (pop_pc_q[k] !== k[15:0] || pop_inst_q[k] !== romword(k[15:0])) begin
        errors++;
        $display("FAIL stream_pc[%0d]: got pc %h inst %h exp pc %h inst %h", k, pop_pc_q[k], pop_inst_q[k], k[15:0], romword(k[15:0]));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1;
    inst_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (iss_q.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d exp 4", iss_q.size()); end
    for (int k = 0; k < 4 && k < iss_q.size(); k++) begin
      checks++; if (iss_q[k] !== k[15:0]) begin errors++; $display("FAIL bp_addr[%0d]: got %h exp %h", k, iss_q[k], k[15:0]); end
    end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_req_stalled: got %b exp 0", s_req); end
    checks++; if (s_iv !== 1'b1 || s_pc !== 16'h0000) begin errors++; $display("FAIL bp_head: got valid %b pc %h exp 1 0000", s_iv, s_pc); end
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (iss_q.size() < 5) begin errors++; $display("FAIL bp_resume: got %0d requests exp >4", iss_q.size()); end
    else if (iss_q[4] !== 16'h0004) begin errors++; $display("FAIL bp_resume: got %h exp 0004", iss_q[4]); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= pop_pc_q.size()) begin errors++; $display("FAIL bp_pop[%0d]: got none exp %h", k, k[15:0]); end
      else if (pop_pc_q[k] !== k[15:0]) begin errors++; $display("FAIL bp_pop[%0d]: got %h exp %h", k, pop_pc_q[k], k[15:0]); end
    end
  endtask

  task automatic test_redirect();
    int n_iss;
    logic stale;
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'h0000; exp_pc[1] = 16'h0001; exp_pc[2] = 16'h0040; exp_pc[3] = 16'h0041;
    do_reset();
    lat = 2;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    checks++; if (issued - delivered != 2) begin errors++; $display("FAIL redir_in_flight: got %0d exp 2", issued - delivered); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    n_iss = iss_q.size();
    tick();
    redirect_valid = 1'b0;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b exp 0", s_req); end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (iss_q.size() <= n_iss) begin errors++; $display("FAIL redir_first_addr: got none exp 0040"); end
    else if (iss_q[n_iss] !== 16'h0040) begin errors++; $display("FAIL redir_first_addr: got %h exp 0040", iss_q[n_iss]); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= pop_pc_q.size()) begin errors++; $display("FAIL redir_pop[%0d]: got none exp %h", k, exp_pc[k]); end
      else if (pop_pc_q[k] !== exp_pc[k] || pop_inst_q[k] !== romword(exp_pc[k])) begin
        errors++;
        $display("FAIL redir_pop[%0d]: got pc %h inst %h exp pc %h inst %h", k, pop_pc_q[k], pop_inst_q[k], exp_pc[k], romword(exp_pc[k]));
      end
    end
    stale = 1'b0;
    foreach (pop_pc_q[k]) if (pop_pc_q[k] == 16'h0002 || pop_pc_q[k] == 16'h0003) stale = 1'b1;
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL redir_stale_popped: got %b exp 0", stale); end
  endtask

  task automatic test_halt();
    logic found;
    int n_iss;
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_req && s_addr == 16'h0005) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL halt_reach_pc5: got no request for 0005 exp one"); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_iss = iss_q.size();
    for (int i = 0; i < 6; i++) tick();
    checks++; if (iss_q.size() != n_iss) begin errors++; $display("FAIL halt_no_issue: got %0d requests exp %0d", iss_q.size(), n_iss); end
    checks++; if (state_o !== ST_HALTED) begin errors++; $display("FAIL halt_state: got %0d exp %0d", state_o, ST_HALTED); end
    checks++; if (pop_pc_q.size() != iss_q.size()) begin errors++; $display("FAIL halt_drain: got %0d pops exp %0d", pop_pc_q.size(), iss_q.size()); end
    for (int k = 0; k < pop_pc_q.size(); k++) begin
      checks++; if (pop_pc_q[k] !== k[15:0]) begin errors++; $display("FAIL halt_pop[%0d]: got %h exp %h", k, pop_pc_q[k], k[15:0]); end
    end
    checks++; if (s_iv !== 1'b0) begin errors++; $display("FAIL halt_empty: got %b exp 0", s_iv); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL restart_no_issue: got %b exp 0", s_req); end
    n_iss = iss_q.size();
    tick();
    tick();
    checks++;
    if (iss_q.size() <= n_iss) begin errors++; $display("FAIL restart_addr: got none exp 0000"); end
    else if (iss_q[n_iss] !== 16'h0000) begin errors++; $display("FAIL restart_addr: got %h exp 0000", iss_q[n_iss]); end
    checks++; if (state_o !== ST_RUN) begin errors++; $display("FAIL restart_state: got %0d exp %0d", state_o, ST_RUN); end
  endtask

  task automatic test_wrap_and_reset();
    int n_iss, n_pop, bad_v, bad_r;
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    n_iss = iss_q.size();
    n_pop = pop_pc_q.size();
    for (int i = 0; i < 8; i++) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (n_iss + k >= iss_q.size()) begin errors++; $display("FAIL wrap_addr[%0d]: got none exp %h", k, exp_pc[k]); end
      else if (iss_q[n_iss+k] !== exp_pc[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h exp %h", k, iss_q[n_iss+k], exp_pc[k]); end
      checks++;
      if (n_pop + k >= pop_pc_q.size()) begin errors++; $display("FAIL wrap_pop[%0d]: got none exp %h", k, exp_pc[k]); end
      else if (pop_pc_q[n_pop+k] !== exp_pc[k]) begin errors++; $display("FAIL wrap_pop[%0d]: got %h exp %h", k, pop_pc_q[n_pop+k], exp_pc[k]); end
    end
    // Build up a queue with responses still in flight, then reset mid-cycle.
    lat = 3;
    inst_ready = 1'b0;
    tick();
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL prereset_valid: got %b exp 1", inst_valid); end
    RST_N = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b exp 0", inst_valid); end
    checks++; if (rom_req !== 1'b0 || rom_addr !== 16'h0000) begin errors++; $display("FAIL async_reset_rom: got req %b addr %h exp 0 0000", rom_req, rom_addr); end
    tick();
    RST_N = 1'b1;
    inst_ready = 1'b1;
    bad_v = 0;
    bad_r = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_iv !== 1'b0) bad_v++;
      if (s_req !== 1'b0) bad_r++;
    end
    checks++; if (bad_v != 0) begin errors++; $display("FAIL late_resp_ignored: got %0d valid cycles exp 0", bad_v); end
    checks++; if (bad_r != 0) begin errors++; $display("FAIL post_reset_idle: got %0d request cycles exp 0", bad_r); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL post_reset_state: got %0d exp %0d", state_o, ST_IDLE); end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    logic hit;
    do_reset();
    checks++; if (fetched_cnt !== 16'h0 || flushed_cnt !== 16'h0) begin errors++; $display("FAIL stats_reset: got %h %h exp 0000 0000", fetched_cnt, flushed_cnt); end
    lat = 1;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && popped < 10; i++) tick();
    inst_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if ((delivered - popped) == 3 && (issued - delivered) == 1) hit = 1'b1;
      else tick();
    end
    checks++; if (!hit) begin errors++; $display("FAIL stats_setup: got queued %0d outstanding %0d exp 3 1", delivered - popped, issued - delivered); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (fetched_cnt !== 16'd10) begin errors++; $display("FAIL stats_fetched: got %0d exp 10", fetched_cnt); end
    checks++; if (flushed_cnt !== 16'd4) begin errors++; $display("FAIL stats_flushed: got %0d exp 4", flushed_cnt); end
  endtask
`endif

  // ---------------- sequence ----------------
  initial begin
    RST_N = 1'b0;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    inst_ready = 1'b0; rom_valid = 1'b0; rom_data = 10'h0;
    clear_bench();
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap_and_reset();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
